// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle ARM control unit: FSM states, condition codes,
// ALU and datapath mux encodings, and the per-state control word.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_CMP = 4'b1010;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  typedef struct packed {
    logic       nextPc;
    logic       branch;
    logic       regW;
    logic       memW;
    logic       irWrite;
    logic       adrSrc;
    logic [1:0] resultSrc;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic       aluOp;
  } ctrl_t;

  // Unconditional control word of each state; condition gating is applied later.
  function automatic ctrl_t stateCtrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.irWrite   = 1'b1;
        c.nextPc    = 1'b1;
        c.aluSrcA   = 1'b1;
        c.aluSrcB   = SRCB_FOUR;
        c.resultSrc = RES_ALURESULT;
      end
      DECODE: begin
        c.aluSrcA   = 1'b1;
        c.aluSrcB   = SRCB_FOUR;
        c.resultSrc = RES_ALURESULT;
      end
      MEMADR:   c.aluSrcB = SRCB_IMM;
      MEMREAD:  c.adrSrc  = 1'b1;
      MEMWB: begin
        c.resultSrc = RES_DATA;
        c.regW      = 1'b1;
      end
      MEMWRITE: begin
        c.adrSrc = 1'b1;
        c.memW   = 1'b1;
      end
      EXECR: begin
        c.aluSrcB = SRCB_REG;
        c.aluOp   = 1'b1;
      end
      EXECI: begin
        c.aluSrcB = SRCB_IMM;
        c.aluOp   = 1'b1;
      end
      ALUWB: begin
        c.resultSrc = RES_ALUOUT;
        c.regW      = 1'b1;
      end
      BRANCH: begin
        c.aluSrcB   = SRCB_IMM;
        c.resultSrc = RES_ALURESULT;
        c.branch    = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction/flag inputs and control outputs between the control unit (master)
// and the multicycle datapath (slave).
interface multicycle_ctrl_if;
  logic [31:12] Instr;
  logic [3:0]   ALUFlags;
  logic         PCWrite;
  logic         MemWrite;
  logic         RegWrite;
  logic         IRWrite;
  logic         AdrSrc;
  logic [1:0]   ResultSrc;
  logic         ALUSrcA;
  logic [1:0]   ALUSrcB;
  logic [1:0]   ALUControl;
  logic [1:0]   ImmSrc;
  logic [1:0]   RegSrc;
  logic [3:0]   State;

  modport master (
    input  Instr, ALUFlags,
    output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, State
  );

  modport slave (
    output Instr, ALUFlags,
    input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, State
  );
endinterface

// File: rtl/multicycle_ctrl_cond_eval.sv
// ARM condition-code evaluation against the {N,Z,C,V} flag register.
module cond_eval
  import multicycle_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       condEx
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  // The reserved 1111 code falls into the default and never executes.
  always_comb begin
    condEx = 1'b0;
    case (cond)
      COND_EQ: condEx = z;
      COND_NE: condEx = ~z;
      COND_CS: condEx = c;
      COND_CC: condEx = ~c;
      COND_MI: condEx = n;
      COND_PL: condEx = ~n;
      COND_VS: condEx = v;
      COND_VC: condEx = ~v;
      COND_HI: condEx = c & ~z;
      COND_LS: condEx = ~c | z;
      COND_GE: condEx = (n == v);
      COND_LT: condEx = (n != v);
      COND_GT: condEx = ~z & (n == v);
      COND_LE: condEx = z | (n != v);
      COND_AL: condEx = 1'b1;
      default: condEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle ARM control unit: main FSM, ALU decoder, flag register and condition
// gating of the datapath write strobes.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  multicycle_ctrl_if.master  bus
);

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       unusedRn;

  assign cond     = bus.Instr[31:28];
  assign op       = bus.Instr[27:26];
  assign funct    = bus.Instr[25:20];
  assign rd       = bus.Instr[15:12];
  assign unusedRn = ^bus.Instr[19:16];

  state_t     state, nextState;
  ctrl_t      ctrl;
  logic [3:0] flags;
  logic       condEx, condQ, noWriteQ;
  logic [1:0] aluControl, flagW;
  logic       noWrite;

  cond_eval uCondEval (
    .cond   (cond),
    .flags  (flags),
    .condEx (condEx)
  );

  always_comb begin
    nextState = FETCH;
    case (state)
      FETCH:  nextState = DECODE;
      DECODE: begin
        case (op)
          OP_DP:   nextState = funct[5] ? EXECI : EXECR;
          OP_MEM:  nextState = MEMADR;
          OP_BR:   nextState = BRANCH;
          default: nextState = FETCH;
        endcase
      end
      MEMADR:  nextState = funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD: nextState = MEMWB;
      EXECR:   nextState = ALUWB;
      EXECI:   nextState = ALUWB;
      default: nextState = FETCH;
    endcase
  end

  // ALU decoder; only the execute states look at the data-processing command.
  always_comb begin
    aluControl = ALU_ADD;
    flagW      = 2'b00;
    noWrite    = 1'b0;
    if (ctrl.aluOp) begin
      case (funct[4:1])
        CMD_ADD: aluControl = ALU_ADD;
        CMD_SUB: aluControl = ALU_SUB;
        CMD_AND: aluControl = ALU_AND;
        CMD_ORR: aluControl = ALU_ORR;
        CMD_CMP: begin
          aluControl = ALU_SUB;
          noWrite    = 1'b1;
        end
        default: aluControl = ALU_ADD;
      endcase
      if (funct[0]) begin
        flagW = (funct[4:1] == CMD_ADD || funct[4:1] == CMD_SUB ||
                 funct[4:1] == CMD_CMP) ? 2'b11 : 2'b10;
      end
    end
  end

  // State and its control word are registered together so the selects come straight
  // from flops. noWriteQ is also refreshed on the memory path so a CMP never
  // suppresses the register write of a later load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FETCH;
      ctrl     <= stateCtrl(FETCH);
      flags    <= 4'b0000;
      condQ    <= 1'b0;
      noWriteQ <= 1'b0;
    end else begin
      state <= nextState;
      ctrl  <= stateCtrl(nextState);
      if (state == EXECR || state == EXECI) begin
        if (flagW[1] && condEx) flags[3:2] <= bus.ALUFlags[3:2];
        if (flagW[0] && condEx) flags[1:0] <= bus.ALUFlags[1:0];
      end
      if (state == EXECR || state == EXECI || state == MEMADR || state == MEMREAD) begin
        condQ    <= condEx;
        noWriteQ <= noWrite;
      end
    end
  end

  assign bus.PCWrite    = ~reset & (ctrl.nextPc | (ctrl.branch & condEx) |
                                    (ctrl.regW & (rd == 4'd15) & condQ));
  assign bus.RegWrite   = ~reset & ctrl.regW & condQ & ~noWriteQ;
  assign bus.MemWrite   = ~reset & ctrl.memW & condQ;
  assign bus.IRWrite    = ~reset & ctrl.irWrite;
  assign bus.AdrSrc     = ctrl.adrSrc;
  assign bus.ResultSrc  = ctrl.resultSrc;
  assign bus.ALUSrcA    = ctrl.aluSrcA;
  assign bus.ALUSrcB    = ctrl.aluSrcB;
  assign bus.ALUControl = aluControl;
  assign bus.ImmSrc     = op;
  assign bus.RegSrc     = {op == OP_MEM, op == OP_BR};
  assign bus.State      = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed instructions from the ARM subset
// plus random instruction streams, checked against an instruction-level model.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  logic [3:0] modelFlags = 4'b0000;

  multicycle_ctrl_if bus();

  multicycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic bit condHolds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] mkWord(input bit pcw, input bit memw, input bit regw,
      input bit irw, input bit adr, input logic [1:0] res, input bit srca,
      input logic [1:0] srcb, input logic [1:0] aluc, input logic [1:0] imm,
      input logic [1:0] regsrc);
    return {16'h0, pcw, memw, regw, irw, adr, res, srca, srcb, aluc, imm, regsrc};
  endfunction

  function automatic logic [31:0] obsWord();
    return {16'h0, bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.IRWrite, bus.AdrSrc,
            bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.ImmSrc, bus.RegSrc};
  endfunction

  // Runs one whole instruction starting at a negedge in FETCH and checks every cycle.
  task automatic applyStimulus(input logic [19:0] ins, input logic [3:0] aluFlags,
                               input string tag);
    logic [3:0] cnd, cmd, rd;
    logic [1:0] op, aluc, imm, regsrc;
    logic [5:0] funct;
    bit pass, isCmp, arith;
    state_t seq[$];
    logic [31:0] exp;
    cnd   = ins[19:16];
    op    = ins[15:14];
    funct = ins[13:8];
    rd    = ins[3:0];
    cmd   = funct[4:1];
    bus.Instr    = ins;
    bus.ALUFlags = aluFlags;
    pass   = condHolds(cnd, modelFlags);
    isCmp  = (op == 2'b00) && (cmd == 4'b1010);
    arith  = (cmd == 4'b0100) || (cmd == 4'b0010) || (cmd == 4'b1010);
    imm    = op;
    regsrc = {op == 2'b01, op == 2'b10};
    case (cmd)
      4'b0010, 4'b1010: aluc = 2'b01;
      4'b0000:          aluc = 2'b10;
      4'b1100:          aluc = 2'b11;
      default:          aluc = 2'b00;
    endcase
    seq = '{FETCH, DECODE};
    case (op)
      2'b00: begin
        seq.push_back(funct[5] ? EXECI : EXECR);
        seq.push_back(ALUWB);
      end
      2'b01: begin
        seq.push_back(MEMADR);
        if (funct[0]) begin
          seq.push_back(MEMREAD);
          seq.push_back(MEMWB);
        end else begin
          seq.push_back(MEMWRITE);
        end
      end
      2'b10: seq.push_back(BRANCH);
      default: ;
    endcase
    foreach (seq[i]) begin
      #1;
      checkOutput({tag, "/state"}, {28'h0, bus.State}, {28'h0, seq[i]});
      case (seq[i])
        FETCH:    exp = mkWord(1, 0, 0, 1, 0, 2'b10, 1, 2'b10, 2'b00, imm, regsrc);
        DECODE:   exp = mkWord(0, 0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00, imm, regsrc);
        MEMADR:   exp = mkWord(0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, imm, regsrc);
        MEMREAD:  exp = mkWord(0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, imm, regsrc);
        MEMWB:    exp = mkWord(pass && rd == 15, 0, pass, 0, 0, 2'b01, 0, 2'b00, 2'b00,
                               imm, regsrc);
        MEMWRITE: exp = mkWord(0, pass, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, imm, regsrc);
        EXECR:    exp = mkWord(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, aluc, imm, regsrc);
        EXECI:    exp = mkWord(0, 0, 0, 0, 0, 2'b00, 0, 2'b01, aluc, imm, regsrc);
        ALUWB:    exp = mkWord(pass && rd == 15, 0, pass && !isCmp, 0, 0, 2'b00, 0,
                               2'b00, 2'b00, imm, regsrc);
        default:  exp = mkWord(pass, 0, 0, 0, 0, 2'b10, 0, 2'b01, 2'b00, imm, regsrc);
      endcase
      checkOutput({tag, "/ctrl"}, obsWord(), exp);
      if ((seq[i] == EXECR || seq[i] == EXECI) && pass && funct[0]) begin
        modelFlags[3:2] = aluFlags[3:2];
        if (arith) modelFlags[1:0] = aluFlags[1:0];
      end
      @(negedge clk);
    end
    #1;
    checkOutput({tag, "/flags"}, {28'h0, dut.flags}, {28'h0, modelFlags});
  endtask

  // Abandons a store in MEMWRITE by raising reset asynchronously.
  task automatic applyResetMidStore();
    bus.Instr    = 20'hE5821;
    bus.ALUFlags = 4'b0000;
    for (int i = 0; i < 3; i++) @(negedge clk);
    #1;
    checkOutput("midstore/state", {28'h0, bus.State}, {28'h0, MEMWRITE});
    checkOutput("midstore/memw", {31'h0, bus.MemWrite}, 32'h1);
    reset = 1'b1;
    #1;
    checkOutput("rst_async/state", {28'h0, bus.State}, {28'h0, FETCH});
    checkOutput("rst_async/memw", {31'h0, bus.MemWrite}, 32'h0);
    checkOutput("rst_async/flags", {28'h0, dut.flags}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    modelFlags = 4'b0000;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [19:0] ins;
    logic [3:0]  cmds[5] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
    reset        = 1'b1;
    bus.Instr    = 20'h0;
    bus.ALUFlags = 4'h0;
    #12;
    checkOutput("reset/state", {28'h0, bus.State}, {28'h0, FETCH});
    checkOutput("reset/ctrl", obsWord(),
                mkWord(0, 0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00, 2'b00, 2'b00));
    checkOutput("reset/flags", {28'h0, dut.flags}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    applyStimulus(20'hE0821, 4'b1111, "add");
    applyStimulus(20'hE0521, 4'b0100, "subs");
    applyStimulus(20'h0A000, 4'b0000, "beq");
    applyStimulus(20'h1A000, 4'b0000, "bne");
    applyResetMidStore();
    applyStimulus(20'hE5921, 4'b0000, "ldr");
    applyStimulus(20'hE0921, 4'b0000, "adds0");
    applyStimulus(20'h05821, 4'b0000, "streq");
    applyStimulus(20'hE1520, 4'b1010, "cmp");
    applyStimulus(20'hE5921, 4'b0000, "ldr_after_cmp");
    applyStimulus(20'hE0921, 4'b0000, "adds1");
    applyStimulus(20'hE0121, 4'b1111, "ands");
    applyStimulus(20'hF0821, 4'b1111, "nv_add");
    applyStimulus(20'hF5821, 4'b1111, "nv_str");
    applyStimulus(20'hE082F, 4'b0000, "add_pc");
    applyStimulus(20'hE2821, 4'b0000, "addi");
    applyStimulus(20'hEC000, 4'b0000, "nop");

    for (int k = 0; k < 250; k++) begin
      ins = 20'($urandom);
      if ($urandom_range(0, 2) == 0) ins[19:16] = 4'hE;
      if (ins[15:14] == 2'b00 && $urandom_range(0, 3) != 0)
        ins[12:9] = cmds[$urandom_range(0, 4)];
      applyStimulus(ins, 4'($urandom), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
